// File: rtl/h_gate_sweep_pkg.sv
// Shared constants for the H-gate sweep datapath: S1.2 fixed-point widths,
// the gate pipeline depth and the sequencer state encoding.
package h_gate_sweep_pkg;

    localparam int TOTAL_WIDTH = 4;                 // S1.2 amplitude width
    localparam int FRAC_WIDTH  = 2;                 // fractional bits
    localparam int ADD_WIDTH   = TOTAL_WIDTH + 1;   // sum/difference width, no overflow
    localparam int H_LATENCY   = 3;                 // h_gate_simplified pipeline depth

    // 1/sqrt(2) quantised to S1.2 (0.75)
    localparam logic signed [TOTAL_WIDTH-1:0] INV_SQRT2 = TOTAL_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/h_gate_sweep_gate.sv
// h_gate_simplified: three-stage pipelined Hadamard on one amplitude pair.
// new_alpha = (alpha + beta) * 0.75, new_beta = (alpha - beta) * 0.75, with the
// product floored to S1.2 and wrapped to TOTAL_WIDTH bits.
module h_gate_simplified
    import h_gate_sweep_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TOTAL_WIDTH-1:0] alpha_r,
    input  logic [TOTAL_WIDTH-1:0] alpha_i,
    input  logic [TOTAL_WIDTH-1:0] beta_r,
    input  logic [TOTAL_WIDTH-1:0] beta_i,
    output logic [TOTAL_WIDTH-1:0] new_alpha_r,
    output logic [TOTAL_WIDTH-1:0] new_alpha_i,
    output logic [TOTAL_WIDTH-1:0] new_beta_r,
    output logic [TOTAL_WIDTH-1:0] new_beta_i
);

    localparam int MUL_W = ADD_WIDTH + TOTAL_WIDTH;

    // Scale by 1/sqrt(2), floor to S1.2 and keep the low bits (wraps on overflow)
    function automatic logic signed [TOTAL_WIDTH-1:0] scale_trunc(
        input logic signed [ADD_WIDTH-1:0] s
    );
        logic signed [MUL_W-1:0] prod;
        prod = MUL_W'(s) * MUL_W'(INV_SQRT2);
        return TOTAL_WIDTH'(prod >>> FRAC_WIDTH);
    endfunction

    logic signed [TOTAL_WIDTH-1:0] a_r_p0, a_i_p0, b_r_p0, b_i_p0;
    logic signed [ADD_WIDTH-1:0]   sum_r_p1, sum_i_p1, dif_r_p1, dif_i_p1;
    logic signed [TOTAL_WIDTH-1:0] na_r_p2, na_i_p2, nb_r_p2, nb_i_p2;

    // ---- stage p0: capture the operand pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r_p0 <= '0;
            a_i_p0 <= '0;
            b_r_p0 <= '0;
            b_i_p0 <= '0;
        end else begin
            a_r_p0 <= $signed(alpha_r);
            a_i_p0 <= $signed(alpha_i);
            b_r_p0 <= $signed(beta_r);
            b_i_p0 <= $signed(beta_i);
        end
    end

    // ---- stage p1: full-width sum and difference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r_p1 <= '0;
            sum_i_p1 <= '0;
            dif_r_p1 <= '0;
            dif_i_p1 <= '0;
        end else begin
            sum_r_p1 <= ADD_WIDTH'(a_r_p0) + ADD_WIDTH'(b_r_p0);
            sum_i_p1 <= ADD_WIDTH'(a_i_p0) + ADD_WIDTH'(b_i_p0);
            dif_r_p1 <= ADD_WIDTH'(a_r_p0) - ADD_WIDTH'(b_r_p0);
            dif_i_p1 <= ADD_WIDTH'(a_i_p0) - ADD_WIDTH'(b_i_p0);
        end
    end

    // ---- stage p2: scale and truncate back to S1.2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            na_r_p2 <= '0;
            na_i_p2 <= '0;
            nb_r_p2 <= '0;
            nb_i_p2 <= '0;
        end else begin
            na_r_p2 <= scale_trunc(sum_r_p1);
            na_i_p2 <= scale_trunc(sum_i_p1);
            nb_r_p2 <= scale_trunc(dif_r_p1);
            nb_i_p2 <= scale_trunc(dif_i_p1);
        end
    end

    assign new_alpha_r = na_r_p2;
    assign new_alpha_i = na_i_p2;
    assign new_beta_r  = nb_r_p2;
    assign new_beta_i  = nb_i_p2;

endmodule

// File: rtl/h_gate_sweep.sv
// h_gate_sweep: applies the Hadamard gate on one target qubit across the whole
// amplitude buffer, one pair per cycle, writing results back in place.
// Optional feature: define H_SWEEP_PASS_CNT_EN to add an 8-bit pass_cnt output
// counting completed sweeps.
module h_gate_sweep
    import h_gate_sweep_pkg::*;
#(
    parameter int NUM_QUBITS = 3,
    parameter int H_LATENCY  = h_gate_sweep_pkg::H_LATENCY,
    parameter int TGT_W      = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [NUM_QUBITS-1:0]  wr_addr,
    input  logic [TOTAL_WIDTH-1:0] wr_r,
    input  logic [TOTAL_WIDTH-1:0] wr_i,
    input  logic                   start,
    input  logic [TGT_W-1:0]       target,
    output logic                   busy,
    output logic                   done,
`ifdef H_SWEEP_PASS_CNT_EN
    output logic [7:0]             pass_cnt,
`endif
    input  logic [NUM_QUBITS-1:0]  rd_addr,
    output logic [TOTAL_WIDTH-1:0] rd_r,
    output logic [TOTAL_WIDTH-1:0] rd_i
);

    localparam int DEPTH   = 1 << NUM_QUBITS;
    localparam int PAIRS   = 1 << (NUM_QUBITS - 1);
    localparam int CNT_MAX = (PAIRS > H_LATENCY) ? PAIRS : H_LATENCY;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]      LAST_ISSUE = CNT_W'(PAIRS - 1);
    localparam logic [CNT_W-1:0]      LAST_DRAIN = CNT_W'(H_LATENCY - 1);
    localparam logic [NUM_QUBITS-1:0] ONE_IDX    = NUM_QUBITS'(1);

    logic [TOTAL_WIDTH-1:0] amp_r [DEPTH];
    logic [TOTAL_WIDTH-1:0] amp_i [DEPTH];

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [TGT_W-1:0]      tgt_q;
    logic                  issue;
    logic                  target_ok;
    logic [NUM_QUBITS-1:0] kx, low_mask, lo, hi;

    logic                  dl_vld [H_LATENCY];
    logic [NUM_QUBITS-1:0] dl_lo  [H_LATENCY];
    logic [NUM_QUBITS-1:0] dl_hi  [H_LATENCY];

    logic [TOTAL_WIDTH-1:0] g_a_r, g_a_i, g_b_r, g_b_i;

    assign target_ok = int'(target) < NUM_QUBITS;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state: issue all pairs, wait for the pipeline to empty, pulse done
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start && target_ok) state_nxt = ST_ISSUE;
            ST_ISSUE: if (cnt == LAST_ISSUE)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (cnt == LAST_DRAIN)  state_nxt = ST_DONE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy  = (state != ST_IDLE);
        done  = (state == ST_DONE);
        issue = (state == ST_ISSUE);
    end

    // Pair counter during ISSUE, reused as the drain timer; target latched on start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            tgt_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start && target_ok) tgt_q <= target;
                end
                ST_ISSUE: cnt <= (cnt == LAST_ISSUE) ? '0 : cnt + CNT_W'(1);
                ST_DRAIN: cnt <= cnt + CNT_W'(1);
                default:  cnt <= '0;
            endcase
        end
    end

    // Pair index: insert a 0 at the target bit of k for lo, set it for hi
    always_comb begin
        kx       = NUM_QUBITS'(cnt);
        low_mask = (ONE_IDX << tgt_q) - ONE_IDX;
        lo       = ((kx & ~low_mask) << 1) | (kx & low_mask);
        hi       = lo | (ONE_IDX << tgt_q);
    end

    h_gate_simplified u_gate (
        .clk         (clk),
        .rst_n       (rst_n),
        .alpha_r     (amp_r[lo]),
        .alpha_i     (amp_i[lo]),
        .beta_r      (amp_r[hi]),
        .beta_i      (amp_i[hi]),
        .new_alpha_r (g_a_r),
        .new_alpha_i (g_a_i),
        .new_beta_r  (g_b_r),
        .new_beta_i  (g_b_i)
    );

    // Retire delay line: carries {valid, lo, hi} in step with the gate pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < H_LATENCY; i++) begin
                dl_vld[i] <= 1'b0;
                dl_lo[i]  <= '0;
                dl_hi[i]  <= '0;
            end
        end else begin
            dl_vld[0] <= issue;
            dl_lo[0]  <= lo;
            dl_hi[0]  <= hi;
            for (int i = 1; i < H_LATENCY; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_lo[i]  <= dl_lo[i-1];
                dl_hi[i]  <= dl_hi[i-1];
            end
        end
    end

    // Amplitude buffer: host writes while idle, gate write-back while sweeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                amp_r[i] <= '0;
                amp_i[i] <= '0;
            end
        end else if (state == ST_IDLE) begin
            if (wr_en) begin
                amp_r[wr_addr] <= wr_r;
                amp_i[wr_addr] <= wr_i;
            end
        end else if (dl_vld[H_LATENCY-1]) begin
            amp_r[dl_lo[H_LATENCY-1]] <= g_a_r;
            amp_i[dl_lo[H_LATENCY-1]] <= g_a_i;
            amp_r[dl_hi[H_LATENCY-1]] <= g_b_r;
            amp_i[dl_hi[H_LATENCY-1]] <= g_b_i;
        end
    end

    // Registered readout port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_r <= '0;
            rd_i <= '0;
        end else begin
            rd_r <= amp_r[rd_addr];
            rd_i <= amp_i[rd_addr];
        end
    end

`ifdef H_SWEEP_PASS_CNT_EN
    // Completed-sweep counter, wraps naturally at 8 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pass_cnt <= '0;
        else if (done) pass_cnt <= pass_cnt + 8'd1;
    end
`endif

endmodule

// File: doc/h_gate_sweep.md
# h_gate_sweep

Sequencer that applies the pipelined Hadamard gate to one target qubit across a full state vector. It holds a 2^NUM_QUBITS-entry amplitude buffer, streams every (|…0…>, |…1…>) amplitude pair on the target bit into one `h_gate_simplified` instance at one pair per cycle, and writes the results back in place. It is the issuing and retiring end of the H-gate datapath and sits between the host load/readout port and the gate pipeline in each QFT stage.

## Interface
Parameters:
- NUM_QUBITS, 3, number of qubits; the buffer holds 2^NUM_QUBITS complex amplitudes
- H_LATENCY, 3, gate pipeline depth in cycles; must match `h_gate_simplified`
- TGT_W, $clog2(NUM_QUBITS) (minimum 1), width of target

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write one amplitude; honoured only in IDLE
- wr_addr  in  NUM_QUBITS  basis-state index to write
- wr_r, wr_i  in  `TOTAL_WIDTH` each  S1.2 amplitude to write
- start  in  1  begin a sweep; honoured only in IDLE
- target  in  TGT_W  target qubit index, sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the last write-back is complete
- rd_addr  in  NUM_QUBITS  readout index
- rd_r, rd_i  out  `TOTAL_WIDTH` each  registered buffer contents at rd_addr, 1-cycle latency

## Operation
- FSM states and transitions:
  - IDLE → ISSUE when start=1 and target<NUM_QUBITS.
  - ISSUE → DRAIN after 2^(NUM_QUBITS-1) issues.
  - DRAIN → DONE after H_LATENCY cycles.
  - DONE → IDLE unconditionally.
- Pair enumeration:
  - Counter k runs 0..2^(NUM_QUBITS-1)-1.
  - lo = k with a 0 inserted at bit position target; hi = lo | (1<<target).
  - Each issue cycle presents buf[lo] as alpha and buf[hi] as beta to the gate.
- Retirement:
  - A shift register H_LATENCY deep carries {valid, lo, hi} alongside the gate.
  - When its output is valid, new_alpha is written to buf[lo] and new_beta to buf[hi].
- No read/write hazard: pairs are disjoint and each pair is read exactly once.
- Gate outputs are stored unmodified; wrap and truncation come from the gate's S1.2 arithmetic.
- Boundary cases:
  - start while busy: ignored.
  - start with target≥NUM_QUBITS: ignored; no busy, no done.
  - wr_en outside IDLE: ignored.
  - wr_en and start in the same IDLE cycle: the write lands. The first issue is the next cycle, so it sees the written value.
  - rd_addr during a sweep: returns current, partially updated contents.
- Reset, including mid-sweep:
  - All buffer entries, rd_r, rd_i, counter, delay line, busy and done go to 0; FSM goes to IDLE.
  - The gate instance is reset by the same rst_n, and no stale write-back occurs.

## Timing
- Start accepted in cycle 0; issues occur in cycles 1..P, where P=2^(NUM_QUBITS-1).
- The last write-back lands at the end of cycle P+H_LATENCY; done is high in cycle P+H_LATENCY+1.
- Default configuration: done in cycle 8 after start (4+3+1).
- Next start is accepted in the cycle after done.

## Configuration
- H_SWEEP_PASS_CNT_EN defined:
  - Adds output pass_cnt, 8 bits, reset 0.
  - Increments on every done pulse and wraps 255→0.
- Not defined: port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package / fixed_point_params.vh holds:
  - TOTAL_WIDTH, FRAC_WIDTH and ADD_WIDTH.
  - A new H_LATENCY constant, which both blocks use.
  - The FSM state encoding localparams.
- One sub-module: `h_gate_simplified`, instantiated once. Index insertion and the retire delay line stay inline.

## Test plan
- Load amp[0]=4 (1.0), others 0; start, target=0 → done in cycle 8; amp[0]=amp[1]=3+0i, amp[2..7]=0.
- Same load, target=2 → amp[0]=amp[4]=3, all others 0.
- Load amp[0]=amp[1]=3, target=0 → amp[0]=4, amp[1]=0 (add=6, 6·3>>>2=4).
- Load amp[2]=-4+0i, amp[3]=0, target=0 → amp[2]=amp[3]=-3 (4'b1101); imag parts stay 0.
- Assert rst_n=0 in cycle 2 of ISSUE → busy=0, no done pulse, every rd_addr reads 0 two cycles later.
- Issue start during busy, and start with target=3 while idle → both ignored; exactly one done pulse for the original sweep; with H_SWEEP_PASS_CNT_EN, pass_cnt=1.
